button_pulse_conditioner: RTL and testbench

Front-end stage that turns the raw, bouncing `up`/`down` push-button levels into clean single-cycle command pulses for the duty-cycle modifier (`Modificacion_Ciclo_Trabajo`), whose `up`/`down` inputs it drives directly. Each button gets its own synchronizer, debounce filter and hold-to-repeat generator. Pulses are one `clk_100MHz` cycle wide, so each valid press moves the duty cycle exactly one step. A sustained hold auto-repeats.

---
 rtl/boton_pkg.sv | 32 +++
 rtl/boton_canal.sv | 122 ++++++++++++
 rtl/button_pulse_conditioner.sv | 67 ++++++
 tb/tb_button_pulse_conditioner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/boton_pkg.sv
// Shared types and defaults for the push-button conditioning channels.
// State encoding, default cycle counts and counter sizing helpers.
package boton_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PRESS_CHK   = 3'd1,
    S_HELD        = 3'd2,
    S_REPEAT      = 3'd3,
    S_RELEASE_CHK = 3'd4
  } boton_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 20_000_000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // The largest terminal count is max_count-1, so clog2(max_count) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/boton_canal.sv
// One button channel: 2-FF synchronizer, debounce/hold/repeat FSM and counter.
// pulse_c and held_c are next-cycle values; the top level registers them.
module boton_canal
  import boton_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse_c,
  output logic held_c
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic         s_meta;
  logic         s;
  boton_state_t state;
  boton_state_t state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Synchronizer for the asynchronous raw button level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
    end else begin
      s_meta <= raw;
      s      <= s_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A low sample always wins over a terminal count in HELD/REPEAT
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_c   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (s) state_nxt = S_PRESS_CHK;
      end
      S_PRESS_CHK: begin
        if (!s) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = S_HELD;
          cnt_nxt   = '0;
          pulse_c   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!s) begin
          state_nxt = S_RELEASE_CHK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          if (REPEAT_EN) begin
            state_nxt = S_REPEAT;
            cnt_nxt   = '0;
            pulse_c   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_REPEAT: begin
        if (!s) begin
          state_nxt = S_RELEASE_CHK;
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_nxt = '0;
          pulse_c = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_RELEASE_CHK: begin
        if (s) begin
          state_nxt = S_HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign held_c = (state_nxt == S_HELD) || (state_nxt == S_REPEAT) ||
                  (state_nxt == S_RELEASE_CHK);

endmodule

// File: rtl/button_pulse_conditioner.sv
// Turns bouncing up/down button levels into clean one-cycle step pulses.
// Two independent channels plus a registered output stage with collision suppression.
module button_pulse_conditioner
  import boton_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up,
  output logic down,
  output logic up_held,
  output logic down_held
);

  logic up_pulse_c;
  logic down_pulse_c;
  logic up_held_c;
  logic down_held_c;

  boton_canal #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN)
  ) u_canal_up (
    .clk     (clk_100MHz),
    .rst     (rst),
    .raw     (btn_up_raw),
    .pulse_c (up_pulse_c),
    .held_c  (up_held_c)
  );

  boton_canal #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN)
  ) u_canal_down (
    .clk     (clk_100MHz),
    .rst     (rst),
    .raw     (btn_down_raw),
    .pulse_c (down_pulse_c),
    .held_c  (down_held_c)
  );

  // Simultaneous pulses cancel each other so the modifier never sees both
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      up        <= 1'b0;
      down      <= 1'b0;
      up_held   <= 1'b0;
      down_held <= 1'b0;
    end else begin
      up        <= up_pulse_c & ~down_pulse_c;
      down      <= down_pulse_c & ~up_pulse_c;
      up_held   <= up_held_c;
      down_held <= down_held_c;
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with short debounce/hold/repeat counts.
// A second instance with auto-repeat disabled shares the same stimulus.
module tb_button_pulse_conditioner;

  logic clk;
  logic rst;
  logic btn_up_raw;
  logic btn_down_raw;
  logic up, down, up_held, down_held;
  logic up2, down2, up_held2, down_held2;

  int total = 0;
  int bad   = 0;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8),
    .REPEAT_EN       (1'b1)
  ) dut (
    .clk_100MHz   (clk),
    .rst          (rst),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .up           (up),
    .down         (down),
    .up_held      (up_held),
    .down_held    (down_held)
  );

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8),
    .REPEAT_EN       (1'b0)
  ) dut_norep (
    .clk_100MHz   (clk),
    .rst          (rst),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .up           (up2),
    .down         (down2),
    .up_held      (up_held2),
    .down_held    (down_held2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n edges, then settle 1 time unit past the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    tick(3);
    chk("rst_up", up, 1'b0);
    chk("rst_down", down, 1'b0);
    chk("rst_up_held", up_held, 1'b0);
    chk("rst_down_held", down_held, 1'b0);
    rst = 1'b0;
    tick(3);
    chk("idle_up", up, 1'b0);

    // Clean press: pulse on the 7th edge after the level changes
    btn_up_raw = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      chk($sformatf("clean_up_c%0d", i), up, i == 7);
      chk($sformatf("clean_held_c%0d", i), up_held, i >= 7);
      chk($sformatf("clean_down_c%0d", i), down, 1'b0);
    end
    btn_up_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk($sformatf("rel_held_c%0d", i), up_held, i < 7);
      chk($sformatf("rel_up_c%0d", i), up, 1'b0);
    end

    // Bounce on down: 1,0,1,0 then steady high
    btn_down_raw = 1'b1; tick(1); chk("bnc_down0", down, 1'b0);
    btn_down_raw = 1'b0; tick(1); chk("bnc_down1", down, 1'b0);
    btn_down_raw = 1'b1; tick(1); chk("bnc_down2", down, 1'b0);
    btn_down_raw = 1'b0; tick(1); chk("bnc_down3", down, 1'b0);
    btn_down_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk($sformatf("bnc_down_c%0d", i), down, i == 7);
      chk($sformatf("bnc_dheld_c%0d", i), down_held, i >= 7);
      chk($sformatf("bnc_up_c%0d", i), up, 1'b0);
    end
    btn_down_raw = 1'b0;
    tick(10);
    chk("bnc_dheld_end", down_held, 1'b0);

    // Auto-repeat: press pulse at 7, then 27, 35, 43, 51, 59; release before 67
    btn_up_raw = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      tick(1);
      chk($sformatf("rep_up_c%0d", i), up,
          (i == 7) || (i == 27) || (i == 35) || (i == 43) || (i == 51) || (i == 59));
      chk($sformatf("rep_held_c%0d", i), up_held, (i >= 7) && (i < 69));
      chk($sformatf("norep_up_c%0d", i), up2, i == 7);
      chk($sformatf("norep_held_c%0d", i), up_held2, (i >= 7) && (i < 69));
      if (i == 62) btn_up_raw = 1'b0;
    end

    // Collision: both pulses suppressed, both held flags rise
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk($sformatf("col_up_c%0d", i), up, 1'b0);
      chk($sformatf("col_down_c%0d", i), down, 1'b0);
      chk($sformatf("col_uheld_c%0d", i), up_held, i >= 7);
      chk($sformatf("col_dheld_c%0d", i), down_held, i >= 7);
    end
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    tick(10);
    chk("col_uheld_end", up_held, 1'b0);
    chk("col_dheld_end", down_held, 1'b0);

    // Reset mid-hold at P+25, button still held
    btn_up_raw = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      chk($sformatf("rh_up_c%0d", i), up, (i == 7) || (i == 27));
    end
    chk("rh_held_before", up_held, 1'b1);
    rst = 1'b1;
    #1;
    chk("rh_async_up", up, 1'b0);
    chk("rh_async_held", up_held, 1'b0);
    chk("rh_async_down", down, 1'b0);
    chk("rh_async_held2", up_held2, 1'b0);
    tick(1);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk($sformatf("rh_new_up_c%0d", i), up, i == 7);
      chk($sformatf("rh_new_held_c%0d", i), up_held, i >= 7);
    end
    btn_up_raw = 1'b0;
    tick(10);
    chk("end_up_held", up_held, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
